ram_stream_reader: RTL

//  Read-side master for ram_1r1w_sync: on start_i, reads len_i consecutive words

---
 rtl/ram_stream_pkg.sv | 15 +
 rtl/ram_stream_skid_fifo.sv | 50 +++++
 rtl/ram_stream_reader.sv | 116 +++++++++++
 3 files changed

// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM stream reader.
//   rsr_state_e     : reader FSM states
//   RSR_FIFO_DEPTH  : return-buffer entries; this also sets the read-credit limit
//   rsr_ptr_inc     : FIFO pointer increment that wraps at RSR_FIFO_DEPTH
package ram_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rsr_state_e;

  localparam int RSR_FIFO_DEPTH = 3;

  function automatic logic [1:0] rsr_ptr_inc(input logic [1:0] p);
    return (p == 2'(RSR_FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/ram_stream_skid_fifo.sv
// 3-entry return buffer that sits between the RAM read port and the stream output.
// A push and a pop may occur in the same cycle.
// Ports:
//   clk_i, reset_i : clock, async active-high reset
//   push_i, data_i : write one word; the caller never pushes when the buffer is full
//   pop_i          : drop the head word; the caller pops only when the buffer is non-empty
//   head_o         : word at the head of the buffer
//   count_o        : number of occupied entries, 0..3
module ram_stream_skid_fifo
  import ram_stream_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] head_o,
  output logic [1:0]         count_o
);

  logic [width_p-1:0] mem_q [RSR_FIFO_DEPTH];
  logic [1:0]         wr_ptr_q, rd_ptr_q, count_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < RSR_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= rsr_ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= rsr_ptr_inc(rd_ptr_q);
      // When a push and a pop occur together, the count does not change.
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side master for a 1-cycle-latency synchronous RAM. On start_i it reads
// len_i consecutive words from base_addr_i, wrapping at depth_p, and presents
// them in order on a valid/ready stream.
// Ports:
//   clk_i, reset_i         : clock, async active-high reset
//   start_i, base_addr_i,
//   len_i                  : burst request; sampled only while idle
//   busy_o                 : high while a burst is in progress, including the drain phase
//   done_o                 : 1-cycle pulse after the last word transfers, or after a zero-length start
//   ram_rd_addr_o          : RAM read address
//   ram_rd_data_i          : RAM read data, valid 1 cycle after the address
//   data_o, valid_o,
//   ready_i, last_o        : output stream
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int width_p = 8,
  parameter int depth_p = 128,
  localparam int aw = $clog2(depth_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [aw-1:0]      base_addr_i,
  input  logic [aw:0]        len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [aw-1:0]      ram_rd_addr_o,
  input  logic [width_p-1:0] ram_rd_data_i,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               last_o
);

  localparam logic [aw-1:0] ADDR_MAX = aw'(depth_p - 1);

  rsr_state_e    state_q;
  logic [aw-1:0] addr_q, addr_d;
  logic [aw:0]   issue_left_q, out_left_q;
  logic          pend_q, done_q;
  logic [1:0]    fifo_count;
  logic          issue, xfer, credit_ok;

  // Reads already in flight count against the buffer space. This keeps the
  // 3-entry buffer from overflowing, and issue depends only on registered
  // state, so there is no combinational path from ready_i to the RAM address.
  assign credit_ok = ({1'b0, fifo_count} + {2'b0, pend_q}) < 3'(RSR_FIFO_DEPTH);
  assign issue     = (state_q == RUN) && (issue_left_q != '0) && credit_ok;
  assign addr_d    = (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;

  assign valid_o = (fifo_count != 2'd0);
  assign xfer    = valid_o & ready_i;
  assign last_o  = valid_o && (out_left_q == (aw+1)'(1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      pend_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pend_q <= issue;
      if (xfer) out_left_q <= out_left_q - 1'b1;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              state_q      <= RUN;
              addr_q       <= base_addr_i;
              issue_left_q <= len_i;
              out_left_q   <= len_i;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr_q       <= addr_d;
            issue_left_q <= issue_left_q - 1'b1;
            // Leave RUN as the final read issues.
            if (issue_left_q == (aw+1)'(1)) state_q <= DRAIN;
          end else if (issue_left_q == '0) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer && last_o) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ram_stream_skid_fifo #(.width_p(width_p)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (pend_q),
    .data_i  (ram_rd_data_i),
    .pop_i   (xfer),
    .head_o  (data_o),
    .count_o (fifo_count)
  );

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign ram_rd_addr_o = addr_q;

endmodule
